// File: rtl/fir_controller_if.sv
// Handshake and datapath-control bundle between the FIR controller,
// the sample source and the serial-MAC datapath registers.
interface fir_controller_if #(
    parameter int ADDR_W = 6
);
    logic              input_valid;
    logic              flush;
    logic              input_ready;
    logic              shift_en;
    logic              acc_clear;
    logic              acc_load;
    logic [ADDR_W-1:0] coef_addr;
    logic              out_load;
    logic              output_valid;
    logic              busy;

    // Controller side: consumes the request/abort, drives every enable.
    modport master (
        input  input_valid,
        input  flush,
        output input_ready,
        output shift_en,
        output acc_clear,
        output acc_load,
        output coef_addr,
        output out_load,
        output output_valid,
        output busy
    );

    // Source/datapath side: the mirror image of the controller.
    modport slave (
        output input_valid,
        output flush,
        input  input_ready,
        input  shift_en,
        input  acc_clear,
        input  acc_load,
        input  coef_addr,
        input  out_load,
        input  output_valid,
        input  busy
    );
endinterface

// File: rtl/fir_controller.sv
// Control FSM for a serial-MAC FIR datapath. Takes one sample per
// valid/ready handshake, walks LENGTH multiply-accumulate cycles through
// the coefficient/tap address, then loads the output register and pulses
// output_valid. No arithmetic lives here, only register enables.
module fir_controller #(
    parameter int LENGTH = 64,
    parameter int ADDR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    fir_controller_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LENGTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              output_valid_q, output_valid_d;

    logic inIdle;
    logic inCalc;
    logic inOut;
    logic running;

    assign inIdle  = (state_q == IDLE);
    assign inCalc  = (state_q == CALC);
    assign inOut   = (state_q == OUT);
    assign running = !rst && !bus.flush;

    // Next-state logic: flush wins over everything, and any unused encoding falls back to IDLE.
    always_comb begin
        state_d        = IDLE;
        count_d        = '0;
        output_valid_d = 1'b0;
        if (!bus.flush) begin
            case (state_q)
                IDLE: begin
                    state_d = bus.input_valid ? CALC : IDLE;
                end
                CALC: begin
                    if (count_q == LAST_ADDR) begin
                        state_d = OUT;
                    end else begin
                        state_d = CALC;
                        count_d = count_q + ADDR_W'(1);
                    end
                end
                OUT: begin
                    state_d        = IDLE;
                    output_valid_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, MAC step counter and the registered result-valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            count_q        <= '0;
            output_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            output_valid_q <= output_valid_d;
        end
    end

    // Output decode is gated by rst so everything reads 0 while reset is held,
    // even though IDLE would otherwise advertise input_ready.
    assign bus.input_ready  = running && inIdle;
    assign bus.shift_en     = running && inIdle && bus.input_valid;
    assign bus.acc_clear    = !rst && (bus.flush || (inIdle && bus.input_valid));
    assign bus.acc_load     = running && inCalc;
    assign bus.coef_addr    = (!rst && inCalc) ? count_q : '0;
    assign bus.out_load     = running && inOut;
    assign bus.output_valid = !rst && output_valid_q;
    assign bus.busy         = !rst && (inCalc || inOut);

endmodule

// File: tb/tb_fir_controller.sv
// Directed bench for fir_controller at LENGTH=4. Each cycle the observed
// output vector {input_ready, shift_en, acc_clear, acc_load, coef_addr,
// out_load, output_valid, busy} is compared against hand-derived values.
module tb_fir_controller;

    localparam int LENGTH = 4;
    localparam int ADDR_W = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [8:0] obs;

    fir_controller_if #(.ADDR_W(ADDR_W)) ifc ();

    fir_controller #(
        .LENGTH(LENGTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    assign obs = {ifc.input_ready, ifc.shift_en, ifc.acc_clear, ifc.acc_load,
                  ifc.coef_addr, ifc.out_load, ifc.output_valid, ifc.busy};

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reset behaviour, including an asynchronous reset in the middle of CALC.
    task automatic test_reset();
        rst = 1'b1;
        ifc.input_valid = 1'b0;
        ifc.flush = 1'b0;
        #2;
        checks++;
        if (obs !== 9'b000000000) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %b expected %b", obs, 9'b000000000);
        end
        ifc.input_valid = 1'b1;
        #1;
        checks++;
        if (obs !== 9'b000000000) begin
            errors++;
            $display("[TB] FAIL reset_hold_valid: got %b expected %b", obs, 9'b000000000);
        end
        ifc.input_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if (obs !== 9'b100000000) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b expected %b", obs, 9'b100000000);
        end
        @(negedge clk);
        ifc.input_valid = 1'b1;
        #2;
        checks++;
        if (obs !== 9'b111000000) begin
            errors++;
            $display("[TB] FAIL reset_accept: got %b expected %b", obs, 9'b111000000);
        end
        @(negedge clk);
        ifc.input_valid = 1'b0;
        #2;
        checks++;
        if (obs !== 9'b000100001) begin
            errors++;
            $display("[TB] FAIL reset_calc0: got %b expected %b", obs, 9'b000100001);
        end
        @(negedge clk);
        #2;
        checks++;
        if (obs !== 9'b000101001) begin
            errors++;
            $display("[TB] FAIL reset_calc1: got %b expected %b", obs, 9'b000101001);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 9'b000000000) begin
            errors++;
            $display("[TB] FAIL reset_mid_calc: got %b expected %b", obs, 9'b000000000);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #2;
            checks++;
            if (obs !== 9'b100000000) begin
                errors++;
                $display("[TB] FAIL reset_after_abort cycle %0d: got %b expected %b", i, obs, 9'b100000000);
            end
            @(negedge clk);
        end
    endtask

    // One sample through the full pipeline: accept, 4 MACs, output load, valid pulse.
    task automatic test_single_sample();
        logic [8:0] exp [8];
        exp = '{9'b111000000, 9'b000100001, 9'b000101001, 9'b000110001,
                9'b000111001, 9'b000000101, 9'b100000010, 9'b100000000};
        for (int i = 0; i < 8; i++) begin
            ifc.input_valid = (i == 0);
            ifc.flush = 1'b0;
            #2;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("[TB] FAIL single_sample cycle %0d: got %b expected %b", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        ifc.input_valid = 1'b0;
    endtask

    // input_valid held high: a new sample is taken in the same cycle output_valid rises.
    task automatic test_back_to_back();
        logic [8:0] expv;
        logic       iv;
        int         phase;
        int         ovCount;
        int         acceptCount;
        ovCount = 0;
        acceptCount = 0;
        for (int i = 0; i < 20; i++) begin
            iv = (i <= 12);
            phase = i % 6;
            ifc.input_valid = iv;
            ifc.flush = 1'b0;
            if (i >= 19)
                expv = 9'b100000000;
            else if (phase == 0)
                expv = {1'b1, iv, iv, 1'b0, 2'b00, 1'b0, (i > 0), 1'b0};
            else if (phase <= 4)
                expv = {3'b000, 1'b1, 2'(phase - 1), 1'b0, 1'b0, 1'b1};
            else
                expv = {3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1};
            #2;
            if (ifc.output_valid === 1'b1) ovCount++;
            if (ifc.shift_en === 1'b1) acceptCount++;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", i, obs, expv);
            end
            @(negedge clk);
        end
        ifc.input_valid = 1'b0;
        checks++;
        if (ovCount !== 3) begin
            errors++;
            $display("[TB] FAIL back_to_back_valid_count: got %0d expected %0d", ovCount, 3);
        end
        checks++;
        if (acceptCount !== 3) begin
            errors++;
            $display("[TB] FAIL back_to_back_accept_count: got %0d expected %0d", acceptCount, 3);
        end
    endtask

    // A request raised mid-computation must be ignored entirely.
    task automatic test_ignored_request();
        logic [8:0] exp [8];
        exp = '{9'b111000000, 9'b000100001, 9'b000101001, 9'b000110001,
                9'b000111001, 9'b000000101, 9'b100000010, 9'b100000000};
        for (int i = 0; i < 8; i++) begin
            ifc.input_valid = (i == 0) || (i == 2);
            ifc.flush = 1'b0;
            #2;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("[TB] FAIL ignored_request cycle %0d: got %b expected %b", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        ifc.input_valid = 1'b0;
    endtask

    // Flush mid-CALC, flush racing a request in IDLE, then a clean sample.
    task automatic test_flush();
        logic [8:0] exp [16];
        logic       ivPat [16];
        logic       flPat [16];
        exp = '{9'b111000000, 9'b000100001, 9'b000101001, 9'b001010001,
                9'b100000000, 9'b100000000, 9'b100000000, 9'b001000000,
                9'b100000000, 9'b111000000, 9'b000100001, 9'b000101001,
                9'b000110001, 9'b000111001, 9'b000000101, 9'b100000010};
        ivPat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        flPat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 16; i++) begin
            ifc.input_valid = ivPat[i];
            ifc.flush = flPat[i];
            #2;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("[TB] FAIL flush cycle %0d: got %b expected %b", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        ifc.input_valid = 1'b0;
        ifc.flush = 1'b0;
    endtask

    // Asynchronous reset while in OUT: out_load drops at once and no result is flagged.
    task automatic test_reset_in_out();
        logic [8:0] exp [6];
        exp = '{9'b111000000, 9'b000100001, 9'b000101001, 9'b000110001,
                9'b000111001, 9'b000000101};
        for (int i = 0; i < 6; i++) begin
            ifc.input_valid = (i == 0);
            ifc.flush = 1'b0;
            #2;
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("[TB] FAIL reset_in_out cycle %0d: got %b expected %b", i, obs, exp[i]);
            end
            if (i < 5) @(negedge clk);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 9'b000000000) begin
            errors++;
            $display("[TB] FAIL reset_in_out_async: got %b expected %b", obs, 9'b000000000);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (obs !== 9'b100000000) begin
                errors++;
                $display("[TB] FAIL reset_in_out_after cycle %0d: got %b expected %b", i, obs, 9'b100000000);
            end
            @(negedge clk);
        end
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ifc.input_valid = 1'b0;
        ifc.flush = 1'b0;
        test_reset();
        test_single_sample();
        test_back_to_back();
        test_ignored_request();
        test_flush();
        test_reset_in_out();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
